mem_ctrl: RTL

//  Sole owner of the byte-wide 128KB on-board RAM (en/r_nw/addr/din/dout, 1-cycle sync read).

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_ctrl_arb.sv | 38 +++
 rtl/mem_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the on-board RAM controller (mem_ctrl).
// Holds the FSM state encoding, transfer size codes, the size-to-byte-count
// mapping and byte lane helpers used by the little-endian beat sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Transfer size codes on ls_size_in; code 2'b11 behaves as a word.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Number of byte beats for a size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte lane idx of a little-endian word.
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

  // Word with byte lane idx replaced by b.
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[8*idx +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way requester arbiter for mem_ctrl (LS vs IF).
// Default build: fixed priority, LS wins a tie.
// With MEM_CTRL_RR_EN defined: round-robin, the requester not granted last
// wins a tie; the preference flips on every accepted grant and resets to LS.
module mem_ctrl_arb (
  input  logic clk_in,
  input  logic rst_in,
  input  logic take_in,       // controller is idle and will accept the grant
  input  logic ls_req_in,
  input  logic if_req_in,
  output logic gnt_valid_out,
  output logic gnt_if_out     // 1 = IF granted, 0 = LS granted
);

  assign gnt_valid_out = ls_req_in | if_req_in;

`ifdef MEM_CTRL_RR_EN
  logic prefer_if_q;

  assign gnt_if_out = if_req_in & (~ls_req_in | prefer_if_q);

  // Favour whichever requester did not get the last grant.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prefer_if_q <= 1'b0;
    end else if (take_in && gnt_valid_out) begin
      prefer_if_q <= ~gnt_if_out;
    end
  end
`else
  assign gnt_if_out = if_req_in & ~ls_req_in;

  // Clock, reset and accept strobe only matter for the round-robin pointer.
  logic unused_rr;
  assign unused_rr = ^{clk_in, rst_in, take_in};
`endif

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of the byte-wide on-board RAM (1-cycle sync read).
// Arbitrates instruction fetch (IF, words) and load/store (LS, 1/2/4 bytes),
// splits each transfer into little-endian byte beats and returns the assembled
// word with a one-cycle done pulse.
// Optional feature macro: MEM_CTRL_RR_EN selects round-robin arbitration
// (see mem_ctrl_arb); default is fixed priority LS > IF.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush_in,
  input  logic                  if_valid_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_valid_in,
  input  logic                  ls_wr_in,
  input  logic [1:0]            ls_size_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  output logic                  mem_en_out,
  output logic                  mem_r_nw_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din
);

  // Transfer context latched when a request is granted.
  state_e                state_q;
  logic                  owner_if_q;
  logic                  wr_q;
  logic [2:0]            nbytes_q;
  logic [2:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic                  mem_en_q;

  logic                  gnt_valid;
  logic                  gnt_if;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_nbytes;
  logic                  req_wr;
  logic [1:0]            next_idx;
  logic [1:0]            cap_idx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           captured;
  logic                  last_write_beat;
  logic                  last_read_cycle;
  logic                  abort;

  // A flush withdraws the IF request before arbitration, so a flushed IF
  // never wins, while LS is unaffected.
  mem_ctrl_arb u_arb (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .take_in       (state_q == ST_IDLE),
    .ls_req_in     (ls_valid_in),
    .if_req_in     (if_valid_in & ~flush_in),
    .gnt_valid_out (gnt_valid),
    .gnt_if_out    (gnt_if)
  );

  assign req_addr   = gnt_if ? if_addr_in : ls_addr_in;
  assign req_nbytes = gnt_if ? size_bytes(SIZE_W) : size_bytes(ls_size_in);
  assign req_wr     = ~gnt_if & ls_wr_in;

  // Beat cnt_q is on the bus; read data arriving now belongs to beat cnt_q-1.
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign next_idx  = 2'(cnt_q + 3'd1);
  assign cap_idx   = 2'(cnt_q - 3'd1);
  assign next_addr = base_q + ADDR_WIDTH'(next_idx);
  assign captured  = put_byte(data_q, cap_idx, mem_din);

  assign last_write_beat = (cnt_q == nbytes_q - 3'd1);
  assign last_read_cycle = (cnt_q == nbytes_q);
  assign abort           = owner_if_q & flush_in;

  // Reset overrides the RAM enable in the same cycle so a store interrupted
  // by reset never commits the beat that is on the bus.
  assign mem_en_out = mem_en_q & ~rst_in;

  // Transfer FSM and registered RAM/requester outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of all the others.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      owner_if_q   <= 1'b0;
      wr_q         <= 1'b0;
      nbytes_q     <= 3'd0;
      cnt_q        <= 3'd0;
      base_q       <= '0;
      wdata_q      <= 32'h0;
      data_q       <= 32'h0;
      mem_en_q     <= 1'b0;
      mem_r_nw_out <= 1'b1;
      mem_a_out    <= '0;
      mem_dout     <= 8'h00;
      if_done_out  <= 1'b0;
      if_data_out  <= 32'h0;
      ls_done_out  <= 1'b0;
      ls_rdata_out <= 32'h0;
    end else begin
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_if_q   <= gnt_if;
            wr_q         <= req_wr;
            nbytes_q     <= req_nbytes;
            base_q       <= req_addr;
            wdata_q      <= ls_wdata_in;
            cnt_q        <= 3'd0;
            data_q       <= 32'h0;
            mem_en_q     <= 1'b1;
            mem_r_nw_out <= ~req_wr;
            mem_a_out    <= req_addr;
            if (req_wr) begin
              mem_dout <= ls_wdata_in[7:0];
            end
            state_q <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (abort) begin
            mem_en_q     <= 1'b0;
            mem_r_nw_out <= 1'b1;
            cnt_q        <= 3'd0;
            state_q      <= ST_IDLE;
          end else if (wr_q) begin
            if (last_write_beat) begin
              mem_en_q     <= 1'b0;
              mem_r_nw_out <= 1'b1;
              cnt_q        <= 3'd0;
              ls_done_out  <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              cnt_q     <= cnt_q + 3'd1;
              mem_a_out <= next_addr;
              mem_dout  <= get_byte(wdata_q, next_idx);
            end
          end else begin
            if (cnt_q != 3'd0) begin
              data_q <= captured;
            end
            if (last_read_cycle) begin
              mem_en_q <= 1'b0;
              cnt_q    <= 3'd0;
              if (owner_if_q) begin
                if_done_out <= 1'b1;
                if_data_out <= captured;
              end else begin
                ls_done_out  <= 1'b1;
                ls_rdata_out <= captured;
              end
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
              // The extra capture cycle re-presents the last beat address.
              if (!last_write_beat) begin
                mem_a_out <= next_addr;
              end
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
